// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier with per-operation signed/unsigned mode.
// One Booth step per clock; the result is loaded one edge after the last step and held until the next one.
module booth_seq_multiplier #(
    parameter int WIDTH = 6,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 tc,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int E = WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [E-1:0]         r_a;
    logic [E-1:0]         r_q;
    logic                 r_q1;
    logic [E-1:0]         r_m;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_result;

    logic [E-1:0]         w_x_ext;
    logic [E-1:0]         w_y_ext;
    logic [E-1:0]         w_a_sel;

    // The extra bit keeps unsigned operands non-negative under Booth recoding.
    assign w_x_ext = {tc & x[WIDTH-1], x};
    assign w_y_ext = {tc & y[WIDTH-1], y};

    always_comb begin
        w_a_sel = r_a;
        case ({r_q[0], r_q1})
            2'b01:   w_a_sel = r_a + r_m;
            2'b10:   w_a_sel = r_a - r_m;
            default: w_a_sel = r_a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_q      <= '0;
            r_q1     <= 1'b0;
            r_m      <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_m     <= w_x_ext;
                        r_q     <= w_y_ext;
                        r_q1    <= 1'b0;
                        r_a     <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_cnt == CNT_W'(E)) begin
                        // {A,Q} holds the 2E-bit product; its low 2*WIDTH bits are exact.
                        r_result <= {r_a[WIDTH-2:0], r_q};
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_a   <= {w_a_sel[E-1], w_a_sel[E-1:1]};
                        r_q   <= {w_a_sel[0], r_q[E-1:1]};
                        r_q1  <= r_q[0];
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Randomised and directed checks of booth_seq_multiplier (WIDTH=6 and WIDTH=8 instances)
// against a plain-arithmetic product model.
module tb_booth_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start6, tc6, start8, tc8;
    logic [5:0]  x6, y6;
    logic [7:0]  x8, y8;
    logic        busy6, done6, busy8, done8;
    logic [11:0] result6;
    logic [15:0] result8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    booth_seq_multiplier #(.WIDTH(6)) u_dut6 (
        .clk(clk), .rst(rst), .start(start6), .tc(tc6), .x(x6), .y(y6),
        .busy(busy6), .done(done6), .result(result6)
    );

    booth_seq_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .tc(tc8), .x(x8), .y(y8),
        .busy(busy8), .done(done8), .result(result8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ref6(input bit t, input logic [5:0] a, input logic [5:0] b);
        int p;
        if (t) p = int'($signed(a)) * int'($signed(b));
        else   p = int'(a) * int'(b);
        return p[11:0];
    endfunction

    function automatic logic [15:0] ref8(input bit t, input logic [7:0] a, input logic [7:0] b);
        int p;
        if (t) p = int'($signed(a)) * int'($signed(b));
        else   p = int'(a) * int'(b);
        return p[15:0];
    endfunction

    // One operation on the 6-bit instance; inputs are scrambled while it runs.
    task automatic op6(input bit t, input logic [5:0] a, input logic [5:0] b);
        logic [11:0] exp;
        int k;
        exp = ref6(t, a, b);
        tc6 = t; x6 = a; y6 = b; start6 = 1'b1;
        @(posedge clk); #1;
        start6 = 1'b0;
        check("busy_at_accept", busy6, 1);
        k = 0;
        while (!done6 && k < 40) begin
            x6 = 6'($urandom); y6 = 6'($urandom);
            tc6 = 1'($urandom); start6 = 1'($urandom);
            @(posedge clk); #1;
            k++;
        end
        start6 = 1'b0;
        check("latency6", k, 8);
        check("result6", result6, exp);
        check("busy_in_done", busy6, 1);
        @(posedge clk); #1;
        check("done_low_after", done6, 0);
        check("busy_low_after", busy6, 0);
        check("result6_held", result6, exp);
    endtask

    task automatic op8(input bit t, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] exp;
        int k;
        exp = ref8(t, a, b);
        tc8 = t; x8 = a; y8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        k = 0;
        while (!done8 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check("latency8", k, 10);
        check("result8", result8, exp);
        @(posedge clk); #1;
        check("busy8_low_after", busy8, 0);
    endtask

    initial begin
        logic [5:0] hx[3], hy[3];
        bit         ht[3];
        int         k;

        rst = 1'b0;
        start6 = 1'b0; tc6 = 1'b0; x6 = '0; y6 = '0;
        start8 = 1'b0; tc8 = 1'b0; x8 = '0; y8 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy6, 0);
        check("rst_done", done6, 0);
        check("rst_result", result6, 0);
        check("rst_result8", result8, 0);
        rst = 1'b1;

        // Directed corners, signed and unsigned
        op6(1'b1, 6'd48, 6'd5);      // -16 * 5
        op6(1'b1, 6'd39, 6'd60);     // -25 * -4
        op6(1'b1, 6'd32, 6'd32);     // -32 * -32
        op6(1'b1, 6'd0,  6'd47);     // 0 * -17
        op6(1'b0, 6'd48, 6'd5);
        op6(1'b0, 6'd63, 6'd63);
        op6(1'b1, 6'd63, 6'd63);
        op6(1'b0, 6'd0,  6'd63);

        for (int i = 0; i < 30; i++)
            op6(1'($urandom), 6'($urandom), 6'($urandom));

        // Start held high across three back-to-back operations
        for (int i = 0; i < 3; i++) begin
            hx[i] = 6'($urandom); hy[i] = 6'($urandom); ht[i] = 1'($urandom);
        end
        tc6 = ht[0]; x6 = hx[0]; y6 = hy[0]; start6 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            k = 0;
            do begin
                @(posedge clk); #1;
                k++;
                if (k == 3) begin
                    x6 = 6'($urandom); y6 = 6'($urandom); tc6 = 1'($urandom);
                end
            end while (!done6 && k < 60);
            check("held_result", result6, ref6(ht[i], hx[i], hy[i]));
            if (i > 0) check("held_gap", k, 10);
            if (i < 2) begin
                tc6 = ht[i+1]; x6 = hx[i+1]; y6 = hy[i+1];
            end
        end
        start6 = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a calculation
        tc6 = 1'b1; x6 = 6'd5; y6 = 6'd7; start6 = 1'b1;
        @(posedge clk); #1;
        start6 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", busy6, 0);
        check("midrst_done", done6, 0);
        check("midrst_result", result6, 0);
        tc6 = 1'b1; x6 = 6'd3; y6 = 6'd62; start6 = 1'b1;
        @(posedge clk); #1;
        check("start_in_reset", busy6, 0);
        rst = 1'b1;
        op6(1'b1, 6'd3, 6'd62);      // 3 * -2

        // Wider instance
        op8(1'b1, 8'd128, 8'd127);
        op8(1'b0, 8'd255, 8'd255);
        for (int i = 0; i < 6; i++)
            op8(1'($urandom), 8'($urandom), 8'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
